fft_ctrl_param: RTL and testbench
=================================

FFT_CTRL_PARAM -- requirements
Module: fft_ctrl_param

Interface
REQ-001 Parameter LOGN, default 8, log2 of transform length N = 2^LOGN; legal 2..10.
REQ-002 Parameter DW, default 32, signed real-sample and result width.
REQ-003 Parameter BF_LAT, default 1, butterfly latency in cycles from Bf_load to valid output; legal 1..4.
REQ-004 Clk  in  1  sole clock; all state changes on rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 Start  in  1  begin load+transform; sampled in IDLE only.
REQ-007 Ack  in  1  release result; sampled in DONE only.
REQ-008 In_valid  in  1 / In_ready  out  1 / In_data  in  DW  sample stream.
REQ-009 Inspect  in  LOGN  bin address read in IDLE/DONE.
REQ-010 Result  out  DW  registered real part of inspected bin.
REQ-011 Addr_top, Addr_bot  out  LOGN  / WE_top, WE_bot  out  1  dual-port RAM control.
REQ-012 Rd_top_re  in  DW  top-port synchronous read data, 1-cycle latency.
REQ-013 Wr_sel  out  1  RAM write-data mux: 1 = In_data, 0 = butterfly output.
REQ-014 Twiddle_addr  out  LOGN-1 / Bf_load  out  1 / Bf_ovf  in  1  butterfly interface.
REQ-015 Busy, Done, Overflow  out  1  status.

Function
REQ-016 States: IDLE, LOAD, RUN, DONE; RUN phases ADDR, WAIT, COMP (BF_LAT cycles), WRITE.
REQ-017 IDLE: Start=1 -> LOAD and clear Overflow; Start ignored in every other state.
REQ-018 LOAD: In_ready=1, Wr_sel=1; each cycle with In_valid=1 writes In_data via top port (WE_top=1) at bit-reverse(count, LOGN), then count+1.
REQ-019 LOAD: In_valid=0 cycle holds count and writes nothing; after sample N-1 accepted -> RUN, stage s=0, butterfly k=0.
REQ-020 RUN butterfly addressing: span=2^s, pos=k mod span, Addr_top=(k>>s)*2*span+pos, Addr_bot=Addr_top+span, Twiddle_addr=pos<<(LOGN-1-s).
REQ-021 ADDR drives addresses; WAIT absorbs RAM latency; Bf_load=1 on first COMP cycle only; WRITE asserts WE_top=WE_bot=1, Wr_sel=0; addresses held constant ADDR..WRITE.
REQ-022 After WRITE: k+1; k wraps N/2-1 -> 0 with s+1; after s=LOGN-1, k=N/2-1 -> DONE.
REQ-023 RUN length exactly LOGN*(N/2)*(3+BF_LAT) cycles; Busy=1 throughout LOAD and RUN.
REQ-024 Overflow sticky: set on any WRITE cycle with Bf_ovf=1; cleared only by accepted Start or Reset.
REQ-025 IDLE and DONE: Addr_top=Inspect, WE both 0; Result <= Rd_top_re every cycle, so Result reflects Inspect 2 cycles later.
REQ-026 DONE: Done=1; Ack=1 -> IDLE; Start and Ack simultaneous in DONE -> Ack wins, Start ignored.
REQ-027 WE_top, WE_bot, Bf_load, In_ready are 0 in any state/phase not listed above.

Reset
REQ-028 Reset asserted, any state: immediately state=IDLE, phase=ADDR, counters s,k,count=0, Result=0, Overflow=0, Done=0, Busy=0, all strobes 0, addresses 0.
REQ-029 Reset mid-LOAD or mid-RUN aborts without further RAM writes; RAM contents are not cleared.

Verification
REQ-030 LOGN=3: load 0..7 -> RAM writes to addresses 0,4,2,6,1,5,3,7 in order; In_valid gaps insert no writes.
REQ-031 LOGN=3, BF_LAT=1: RUN lasts 48 cycles; first butterfly top=0 bot=1 tw=0; stage-2 last butterfly top=3 bot=7 tw=3.
REQ-032 Bf_ovf=1 on one WRITE only -> Overflow=1 through DONE and IDLE; next Start clears it to 0.
REQ-033 Start pulsed during RUN and DONE -> no effect; Start+Ack together in DONE -> IDLE, Busy=0 next cycle.
REQ-034 Reset asserted at RUN cycle 20 -> outputs at reset values before next edge, no WE pulse; fresh Start completes normally.
REQ-035 DONE with RAM[5]=0x1234, Inspect=5 -> Result=0x1234 two cycles later.

Source files
------------

// File: rtl/fft_ctrl_param.sv
// In-place radix-2 FFT controller: bit-reversed sample load, staged butterfly
// sequencing over a dual-port RAM, and bin readback through the top port.
module fft_ctrl_param #(
    parameter int LOGN   = 8,
    parameter int DW     = 32,
    parameter int BF_LAT = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_ack,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic signed [DW-1:0] i_in_data,
    input  logic [LOGN-1:0]      i_inspect,
    output logic signed [DW-1:0] o_result,
    output logic [LOGN-1:0]      o_addr_top,
    output logic [LOGN-1:0]      o_addr_bot,
    output logic                 o_we_top,
    output logic                 o_we_bot,
    input  logic signed [DW-1:0] i_rd_top_re,
    output logic                 o_wr_sel,
    output logic [LOGN-2:0]      o_twiddle_addr,
    output logic                 o_bf_load,
    input  logic                 i_bf_ovf,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_overflow,
    output logic [1:0]           o_dbg_state,
    output logic [1:0]           o_dbg_phase
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;
    typedef enum logic [1:0] {P_ADDR, P_WAIT, P_COMP, P_WRITE} phase_t;

    localparam logic [LOGN-1:0] CNT_LAST = '1;
    localparam logic [LOGN-2:0] K_LAST   = '1;
    localparam logic [3:0]      S_LAST   = 4'(LOGN - 1);
    localparam logic [1:0]      LAT_LAST = 2'(BF_LAT - 1);

    state_t                r_state, w_state_nx;
    phase_t                r_phase, w_phase_nx;
    logic [3:0]            r_s, w_s_nx;
    logic [LOGN-2:0]       r_k, w_k_nx;
    logic [LOGN-1:0]       r_count, w_count_nx;
    logic [1:0]            r_lat, w_lat_nx;
    logic                  r_overflow, w_overflow_nx;
    logic signed [DW-1:0]  r_result;

    logic [LOGN-1:0]       w_brev;
    logic [LOGN-1:0]       w_kx;
    logic [LOGN-1:0]       w_span;
    logic [LOGN-2:0]       w_span_k;
    logic [LOGN-2:0]       w_pos;
    logic [LOGN-1:0]       w_top;
    logic [LOGN-1:0]       w_bot;
    logic [LOGN-2:0]       w_tw;

    // Sample data goes straight to the RAM mux; the controller never looks at it.
    logic                  w_unused_in_data;
    assign w_unused_in_data = ^i_in_data;

    always_comb begin
        w_brev = '0;
        for (int i = 0; i < LOGN; i++) begin
            w_brev[i] = r_count[LOGN-1-i];
        end
    end

    // On the last stage span = N/2 wraps to 0 in LOGN-1 bits, so the mask
    // becomes all ones and pos = k, which is exactly what that stage needs.
    always_comb begin
        w_kx     = {1'b0, r_k};
        w_span   = LOGN'(1) << r_s;
        w_span_k = (LOGN-1)'(1) << r_s;
        w_pos    = r_k & (w_span_k - (LOGN-1)'(1));
        w_top    = ((w_kx >> r_s) << (r_s + 4'd1)) | {1'b0, w_pos};
        w_bot    = w_top + w_span;
        w_tw     = w_pos << (S_LAST - r_s);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_phase    <= P_ADDR;
            r_s        <= '0;
            r_k        <= '0;
            r_count    <= '0;
            r_lat      <= '0;
            r_overflow <= 1'b0;
            r_result   <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_phase    <= w_phase_nx;
            r_s        <= w_s_nx;
            r_k        <= w_k_nx;
            r_count    <= w_count_nx;
            r_lat      <= w_lat_nx;
            r_overflow <= w_overflow_nx;
            r_result   <= i_rd_top_re;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_phase_nx     = r_phase;
        w_s_nx         = r_s;
        w_k_nx         = r_k;
        w_count_nx     = r_count;
        w_lat_nx       = r_lat;
        w_overflow_nx  = r_overflow;
        o_addr_top     = '0;
        o_addr_bot     = '0;
        o_we_top       = 1'b0;
        o_we_bot       = 1'b0;
        o_wr_sel       = 1'b0;
        o_twiddle_addr = '0;
        o_bf_load      = 1'b0;
        o_in_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_addr_top = i_inspect;
                if (i_start) begin
                    w_state_nx    = S_LOAD;
                    w_overflow_nx = 1'b0;
                    w_count_nx    = '0;
                end
            end
            S_LOAD: begin
                o_in_ready = 1'b1;
                o_wr_sel   = 1'b1;
                o_addr_top = w_brev;
                if (i_in_valid) begin
                    o_we_top = 1'b1;
                    if (r_count == CNT_LAST) begin
                        w_state_nx = S_RUN;
                        w_phase_nx = P_ADDR;
                        w_s_nx     = '0;
                        w_k_nx     = '0;
                        w_count_nx = '0;
                        w_lat_nx   = '0;
                    end else begin
                        w_count_nx = r_count + LOGN'(1);
                    end
                end
            end
            S_RUN: begin
                o_addr_top     = w_top;
                o_addr_bot     = w_bot;
                o_twiddle_addr = w_tw;
                case (r_phase)
                    P_ADDR: w_phase_nx = P_WAIT;
                    P_WAIT: begin
                        w_phase_nx = P_COMP;
                        w_lat_nx   = '0;
                    end
                    P_COMP: begin
                        o_bf_load = (r_lat == 2'd0);
                        if (r_lat == LAT_LAST) begin
                            w_phase_nx = P_WRITE;
                        end else begin
                            w_lat_nx = r_lat + 2'd1;
                        end
                    end
                    default: begin
                        o_we_top   = 1'b1;
                        o_we_bot   = 1'b1;
                        w_phase_nx = P_ADDR;
                        if (i_bf_ovf) begin
                            w_overflow_nx = 1'b1;
                        end
                        if (r_k == K_LAST) begin
                            w_k_nx = '0;
                            if (r_s == S_LAST) begin
                                w_state_nx = S_DONE;
                                w_s_nx     = '0;
                            end else begin
                                w_s_nx = r_s + 4'd1;
                            end
                        end else begin
                            w_k_nx = r_k + (LOGN-1)'(1);
                        end
                    end
                endcase
            end
            default: begin
                o_addr_top = i_inspect;
                if (i_ack) begin
                    w_state_nx = S_IDLE;
                end
            end
        endcase
        // Reset forces the inspect address to 0 without waiting for an edge.
        if (i_reset) begin
            o_addr_top = '0;
        end
    end

    assign o_result    = r_result;
    assign o_overflow  = r_overflow;
    assign o_busy      = (r_state == S_LOAD) || (r_state == S_RUN);
    assign o_done      = (r_state == S_DONE);
    assign o_dbg_state = r_state;
    assign o_dbg_phase = r_phase;

endmodule

// File: tb/tb_fft_ctrl_param.sv
// Bench for fft_ctrl_param (LOGN=3, BF_LAT=1) with a behavioural RAM and a
// stand-in butterfly (top=a+b, bot=a-b+twiddle) checked against a loop-level FFT-shape model.
module tb_fft_ctrl_param;

    localparam int LOGN    = 3;
    localparam int DW      = 32;
    localparam int BF_LAT  = 1;
    localparam int N       = 1 << LOGN;
    localparam int RUN_LEN = LOGN * (N / 2) * (3 + BF_LAT);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 ack = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] in_data = '0;
    logic [LOGN-1:0]      inspect = '0;
    logic signed [DW-1:0] result;
    logic [LOGN-1:0]      addr_top, addr_bot;
    logic                 we_top, we_bot;
    logic signed [DW-1:0] rd_q;
    logic                 wr_sel;
    logic [LOGN-2:0]      tw_addr;
    logic                 bf_load;
    logic                 bf_ovf;
    logic                 busy, done, overflow;
    logic [1:0]           dbg_state, dbg_phase;

    fft_ctrl_param #(.LOGN(LOGN), .DW(DW), .BF_LAT(BF_LAT)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_ack(ack),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
        .i_inspect(inspect), .o_result(result),
        .o_addr_top(addr_top), .o_addr_bot(addr_bot),
        .o_we_top(we_top), .o_we_bot(we_bot), .i_rd_top_re(rd_q),
        .o_wr_sel(wr_sel), .o_twiddle_addr(tw_addr), .o_bf_load(bf_load),
        .i_bf_ovf(bf_ovf), .o_busy(busy), .o_done(done), .o_overflow(overflow),
        .o_dbg_state(dbg_state), .o_dbg_phase(dbg_phase)
    );

    always #5 clk = ~clk;

    // RAM and butterfly stand-in act on values captured mid-cycle.
    logic signed [DW-1:0] ram [N];
    logic signed [DW-1:0] bf_a, bf_b, c_in_data;
    logic [LOGN-2:0]      bf_tw, c_tw;
    logic [LOGN-1:0]      c_top, c_bot;
    logic                 c_we_top = 1'b0, c_we_bot = 1'b0, c_wr_sel = 1'b0, c_bf_load = 1'b0;

    always @(negedge clk) begin
        c_top     = addr_top;
        c_bot     = addr_bot;
        c_we_top  = we_top;
        c_we_bot  = we_bot;
        c_wr_sel  = wr_sel;
        c_bf_load = bf_load;
        c_tw      = tw_addr;
        c_in_data = in_data;
    end

    always @(posedge clk) begin
        rd_q <= ram[c_top];
        if (c_bf_load) begin
            bf_a  <= ram[c_top];
            bf_b  <= ram[c_bot];
            bf_tw <= c_tw;
        end
        if (c_we_top) ram[c_top] <= c_wr_sel ? c_in_data : bf_a + bf_b;
        if (c_we_bot) ram[c_bot] <= bf_a - bf_b + {{(DW-LOGN+1){1'b0}}, bf_tw};
    end

    logic       ovf_arm = 1'b0;
    int         ovf_at = 0;
    int         wr_n = 0;
    assign bf_ovf = ovf_arm && we_bot && (wr_n == ovf_at);

    int total = 0;
    int bad = 0;
    int run_cyc, bf_n, we_seen;
    logic in_load = 1'b0;
    logic [LOGN-1:0] first_top, first_bot, last_top, last_bot;
    logic [LOGN-2:0] first_tw, last_tw;
    logic [LOGN-1:0] exp_q[$];
    logic signed [DW-1:0] samples [N];
    logic signed [DW-1:0] exp_ram [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LOGN-1:0] brev(input int v);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) r[i] = v[LOGN-1-i];
        return r;
    endfunction

    // Reference: bit-reversed placement, then per stage, groups of 2*span
    // with butterflies (g+j, g+j+span) and twiddle j scaled to the stage.
    task automatic compute_model();
        logic signed [DW-1:0] a, b;
        for (int i = 0; i < N; i++) exp_ram[brev(i)] = samples[i];
        for (int s = 0; s < LOGN; s++) begin
            int span = 1 << s;
            for (int g = 0; g < N; g += 2 * span) begin
                for (int j = 0; j < span; j++) begin
                    a = exp_ram[g+j];
                    b = exp_ram[g+j+span];
                    exp_ram[g+j]      = a + b;
                    exp_ram[g+j+span] = a - b + (j << (LOGN - 1 - s));
                end
            end
        end
    endtask

    // One clock: observe at the falling edge, return 1 time unit after the rising edge.
    task automatic cycle();
        logic was_write;
        @(negedge clk);
        if (busy && !in_ready) run_cyc++;
        if (we_top || we_bot) we_seen++;
        if (in_load) begin
            chk("in_ready", in_ready, 1'b1);
            chk("load_we", we_top, in_valid);
        end
        if (we_top && wr_sel) begin
            if (exp_q.size() > 0) chk("load_addr", addr_top, exp_q.pop_front());
            else chk("load_overrun", we_top, 1'b0);
        end
        if (bf_load) begin
            if (bf_n == 0) begin
                first_top = addr_top; first_bot = addr_bot; first_tw = tw_addr;
            end
            last_top = addr_top; last_bot = addr_bot; last_tw = tw_addr;
            bf_n++;
        end
        was_write = we_bot;
        @(posedge clk);
        #1;
        if (was_write) wr_n++;
    endtask

    task automatic start_and_load();
        for (int i = 0; i < N; i++) begin
            samples[i] = $signed($urandom_range(0, 4000)) - 2000;
            exp_q.push_back(brev(i));
        end
        compute_model();
        start = 1'b1;
        cycle();
        start = 1'b0;
        in_load = 1'b1;
        for (int i = 0; i < N; i++) begin
            int gaps = $urandom_range(0, 2);
            in_valid = 1'b0;
            for (int g = 0; g < gaps; g++) cycle();
            in_valid = 1'b1;
            in_data = samples[i];
            cycle();
        end
        in_valid = 1'b0;
        in_load = 1'b0;
        chk("load_all_addrs", exp_q.size(), 0);
        run_cyc = 0;
        bf_n = 0;
        wr_n = 0;
    endtask

    task automatic run_to_done(input bit poke_start);
        for (int i = 0; i < 300 && !done; i++) begin
            start = poke_start && ($urandom_range(0, 5) == 0);
            cycle();
        end
        start = 1'b0;
        chk("done_reached", done, 1'b1);
        chk("run_len", run_cyc, RUN_LEN);
        chk("bf_count", bf_n, LOGN * N / 2);
        chk("first_top", first_top, 0);
        chk("first_bot", first_bot, 1);
        chk("first_tw", first_tw, 0);
        chk("last_top", last_top, 3);
        chk("last_bot", last_bot, 7);
        chk("last_tw", last_tw, 3);
        chk("busy_done", busy, 1'b0);
    endtask

    task automatic check_bins();
        for (int b = 0; b < N; b++) begin
            inspect = LOGN'(b);
            cycle();
            cycle();
            chk($sformatf("bin%0d", b), result, exp_ram[b]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_result", result, 0);
        chk("rst_we", {we_top, we_bot, bf_load, in_ready}, 0);
        chk("rst_addr", {addr_top, addr_bot}, 0);
        rst = 1'b0;
        cycle();

        // Run 1: one overflowing WRITE, Start poked during RUN and DONE.
        ovf_arm = 1'b1;
        ovf_at = $urandom_range(0, LOGN * N / 2 - 1);
        start_and_load();
        run_to_done(1'b1);
        chk("ovf_set_done", overflow, 1'b1);
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("start_in_done", done, 1'b1);
        chk("start_in_done_busy", busy, 1'b0);
        check_bins();
        chk("ovf_hold_done", overflow, 1'b1);
        start = 1'b1;
        ack = 1'b1;
        cycle();
        start = 1'b0;
        ack = 1'b0;
        chk("ack_wins_done", done, 1'b0);
        chk("ack_wins_busy", busy, 1'b0);
        chk("ovf_hold_idle", overflow, 1'b1);
        cycle();
        chk("idle_stays", busy, 1'b0);

        // Run 2: clean run; Start clears the sticky flag.
        ovf_arm = 1'b0;
        start_and_load();
        chk("ovf_cleared", overflow, 1'b0);
        run_to_done(1'b0);
        chk("ovf_clean", overflow, 1'b0);
        check_bins();
        ack = 1'b1;
        cycle();
        ack = 1'b0;
        chk("ack_idle", done, 1'b0);

        // Run 3: reset at RUN cycle 20, then a fresh run.
        start_and_load();
        for (int i = 0; i < 100 && run_cyc < 20; i++) cycle();
        chk("reach_run20", run_cyc, 20);
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_strobes", {we_top, we_bot, bf_load, in_ready}, 0);
        chk("arst_addr", {addr_top, addr_bot, tw_addr}, 0);
        chk("arst_result", result, 0);
        chk("arst_ovf_done", {overflow, done}, 0);
        we_seen = 0;
        cycle();
        cycle();
        chk("arst_no_we", we_seen, 0);
        rst = 1'b0;
        cycle();
        start_and_load();
        run_to_done(1'b0);
        check_bins();
        ack = 1'b1;
        cycle();
        ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
